// File: rtl/dsc_stream_if.sv
// Stochastic bitstream beat channel: one bit per operand per beat, with
// valid/ready handshake and an end-of-run marker.
interface dsc_stream_if #(
  parameter int NUM_INPUTS = 2
);
  logic [NUM_INPUTS-1:0] stream_out;
  logic                  stream_valid;
  logic                  stream_ready;
  logic                  stream_last;

  modport master (
    output stream_out,
    output stream_valid,
    output stream_last,
    input  stream_ready
  );

  modport slave (
    input  stream_out,
    input  stream_valid,
    input  stream_last,
    output stream_ready
  );
endinterface

// File: rtl/dsc_stream_gen.sv
// Deterministic stochastic-computing stream generator. Each captured operand
// is compared against its own counter to produce a unary bitstream; the
// counters are chained like digits of one wide counter (clock division), so
// one run walks every combination of counter values exactly once and the AND
// of all streams carries exactly the product of the operands in ones.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands and counters captured on start
// RUN   | presenting beats; counters advance on every accepted beat
// DONE  | single-cycle done pulse after the last beat, then back to IDLE
module dsc_stream_gen #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] bin_data_in [NUM_INPUTS-1:0],
  dsc_stream_if.master          sif,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] operand [NUM_INPUTS-1:0];
  logic [DATA_WIDTH-1:0] cnt     [NUM_INPUTS-1:0];
  logic [NUM_INPUTS-1:0] inc_en;
  logic                  accept;
  logic                  all_max;
  logic                  capture;

  assign accept = (state == RUN) && sif.stream_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode; start only matters in IDLE.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (accept && all_max) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter i advances only when all lower counters sit at their maximum,
  // computed per stage from the counters directly to keep the chain acyclic.
  always_comb begin
    inc_en  = '0;
    all_max = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      inc_en[i] = accept;
      for (int j = 0; j < i; j++) begin
        if (cnt[j] != '1) inc_en[i] = 1'b0;
      end
      if (cnt[i] != '1) all_max = 1'b0;
    end
  end

  // Operand capture and digit counters; the final accepted beat wraps all
  // counters back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        operand[i] <= '0;
        cnt[i]     <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        operand[i] <= bin_data_in[i];
        cnt[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (inc_en[i]) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Beat outputs are pure functions of state and counters, so a stall holds them.
  always_comb begin
    sif.stream_out = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      sif.stream_out[i] = (state == RUN) && (operand[i] > cnt[i]);
    end
    sif.stream_valid = (state == RUN);
    sif.stream_last  = (state == RUN) && all_max;
    busy             = (state != IDLE);
    done             = (state == DONE);
  end

endmodule

// File: tb/tb_dsc_stream_gen.sv
// Scoreboard bench for dsc_stream_gen: every accepted start pushes the full
// expected beat sequence (beat k's counter values are the base-2^DW digits
// of k); a negedge monitor pops and compares each accepted beat.
module tb_dsc_stream_gen;
  localparam int DW      = 5;
  localparam int NI      = 2;
  localparam int RUN_LEN = 1 << (DW * NI);
  localparam int RADIX   = 1 << DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] bin_data_in [NI-1:0];
  logic          busy, done;

  dsc_stream_if #(.NUM_INPUTS(NI)) sif ();

  dsc_stream_gen #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bin_data_in (bin_data_in),
    .sif         (sif),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [NI-1:0] out;
    logic          last;
  } beat_t;

  beat_t exp_q [$];

  int total = 0;
  int bad   = 0;
  int beats, ones_and, last_seen, last_beat, first_cyc, done_cnt, stalls;
  int ones [NI];
  bit rand_ready = 1'b0;
  logic          stall_prev = 1'b0;
  logic [NI-1:0] prev_out;
  logic          prev_last;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    beats = 0; ones_and = 0; last_seen = 0; last_beat = 0;
    first_cyc = -1; stalls = 0;
    for (int i = 0; i < NI; i++) ones[i] = 0;
  endtask

  // Reference: beat k holds counter values digit_i(k) = (k / RADIX^i) % RADIX.
  task automatic push_run(input int a, input int b);
    int op [NI];
    beat_t e;
    op[0] = a; op[1] = b;
    for (int k = 0; k < RUN_LEN; k++) begin
      for (int i = 0; i < NI; i++)
        e.out[i] = (op[i] > ((k / (RADIX ** i)) % RADIX));
      e.last = (k == RUN_LEN - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_run(input int a, input int b, input bit hold, output int t0);
    @(posedge clk); #1;
    bin_data_in[0] = DW'(a);
    bin_data_in[1] = DW'(b);
    clear_stats();
    push_run(a, b);
    start = 1'b1;
    t0 = cyc;
    if (!hold) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int n = 0; n < RUN_LEN * 8; n++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        break;
      end
    end
    chk("done_seen", int'(dc >= 0), 1);
  endtask

  task automatic wait_beats(input int n);
    int k = 0;
    while (beats < n && k < RUN_LEN * 8) begin
      @(negedge clk);
      k++;
    end
    chk("beats_reached", int'(beats >= n), 1);
  endtask

  task automatic check_run(input int a, input int b);
    chk("run_beats", beats, RUN_LEN);
    chk("ones_s0", ones[0], a * (RUN_LEN / RADIX));
    chk("ones_s1", ones[1], b * (RUN_LEN / RADIX));
    chk("ones_and", ones_and, a * b);
    chk("last_count", last_seen, 1);
    chk("last_beat_idx", last_beat, RUN_LEN);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_after_done();
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("busy_after_done", int'(busy), 0);
    chk("valid_after_done", int'(sif.stream_valid), 0);
  endtask

  // Ready driver: always high or ~50% random.
  always @(posedge clk) begin
    #1;
    sif.stream_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: compare each accepted beat against the scoreboard, check stalls.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      if (stall_prev && sif.stream_valid) begin
        chk("stall_out", int'(sif.stream_out), int'(prev_out));
        chk("stall_last", int'(sif.stream_last), int'(prev_last));
      end
      if (sif.stream_valid && sif.stream_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_out", int'(sif.stream_out), int'(e.out));
          chk("beat_last", int'(sif.stream_last), int'(e.last));
        end
        if (beats == 0) first_cyc = cyc;
        beats++;
        for (int i = 0; i < NI; i++) ones[i] += int'(sif.stream_out[i]);
        ones_and += int'(&sif.stream_out);
        if (sif.stream_last) begin
          last_seen++;
          last_beat = beats;
        end
      end
      if (sif.stream_valid && !sif.stream_ready) stalls++;
      stall_prev = sif.stream_valid && !sif.stream_ready;
      prev_out   = sif.stream_out;
      prev_last  = sif.stream_last;
      if (done) done_cnt++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, dc;
    sif.stream_ready = 1'b1;
    bin_data_in[0] = '0;
    bin_data_in[1] = '0;
    clear_stats();
    done_cnt = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(sif.stream_valid), 0);
    chk("rst_out", int'(sif.stream_out), 0);
    chk("rst_last", int'(sif.stream_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);

    // {3,5}, ready high: exact latency and counts.
    start_run(3, 5, 1'b0, t0);
    wait_done(dc);
    chk("done_latency", dc, t0 + RUN_LEN + 1);
    check_run(3, 5);
    check_after_done();

    // Boundary operands.
    start_run(0, 31, 1'b0, t0);
    wait_done(dc);
    check_run(0, 31);
    check_after_done();
    start_run(31, 31, 1'b0, t0);
    wait_done(dc);
    check_run(31, 31);
    check_after_done();

    // {7,9} with random back-pressure.
    rand_ready = 1'b1;
    start_run(7, 9, 1'b0, t0);
    wait_done(dc);
    rand_ready = 1'b0;
    check_run(7, 9);
    chk("stalls_happened", int'(stalls > 0), 1);
    check_after_done();

    // start pulse mid-run with new operands must be ignored.
    start_run(6, 4, 1'b0, t0);
    wait_beats(100);
    @(posedge clk); #1;
    bin_data_in[0] = 5'd25;
    bin_data_in[1] = 5'd30;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(dc);
    check_run(6, 4);
    check_after_done();

    // Reset mid-run aborts without a done pulse.
    start_run(7, 9, 1'b0, t0);
    wait_beats(500);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_valid", int'(sif.stream_valid), 0);
    chk("abort_out", int'(sif.stream_out), 0);
    chk("abort_last", int'(sif.stream_last), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    exp_q.delete();
    done_cnt = 0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle_busy", int'(busy), 0);
    chk("abort_idle_valid", int'(sif.stream_valid), 0);
    start_run(2, 2, 1'b0, t0);
    wait_done(dc);
    check_run(2, 2);
    check_after_done();

    // Back-to-back: start held through DONE restarts only from IDLE.
    start_run(1, 3, 1'b1, t0);
    wait_done(dc);
    check_run(1, 3);
    clear_stats();
    push_run(1, 3);
    check_after_done();
    wait_beats(1);
    start = 1'b0;
    chk("b2b_first_beat", first_cyc, dc + 2);
    wait_done(dc);
    check_run(1, 3);
    check_after_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
